// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle control FSM for the 16-bit core. Accepts one
//               instruction per valid/ready handshake and latches its opcode
//               and type. It then walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK/
//               DISPLAY/TRAP, raising one phase's datapath enables at a time.
//               The MEM wait is bounded by a timeout. Unknown encodings
//               trap instead of issuing a NOP.
// Ports       : clk, rst                 - clock, sync active-high reset
//               instr_valid/instr_ready  - fetch handshake
//               opcode, instr_type       - fields sampled on accept
//               mem_ack                  - data memory completion
//               ir_load, mem_read_en, mem_write_en, reg_write_en,
//               data_to_reg, alu_imm, flag_en, display - datapath controls
//               instr_done, illegal, mem_timeout       - status pulses
//               state                    - current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int OPCODE_W    = 5,
    parameter int TYPE_W      = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [TYPE_W-1:0]   instr_type,
    input  logic                mem_ack,
    output logic                ir_load,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                reg_write_en,
    output logic [1:0]          data_to_reg,
    output logic                alu_imm,
    output logic                flag_en,
    output logic                display,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_timeout,
    output logic [2:0]          state
);

    localparam logic [2:0] C_ST_FETCH   = 3'd0;
    localparam logic [2:0] C_ST_DECODE  = 3'd1;
    localparam logic [2:0] C_ST_EXECUTE = 3'd2;
    localparam logic [2:0] C_ST_MEM     = 3'd3;
    localparam logic [2:0] C_ST_WB      = 3'd4;
    localparam logic [2:0] C_ST_DISPLAY = 3'd5;
    localparam logic [2:0] C_ST_TRAP    = 3'd6;

    // Instruction classes derived from the latched fields
    localparam logic [2:0] C_CL_ALU   = 3'd0;
    localparam logic [2:0] C_CL_CMP   = 3'd1;
    localparam logic [2:0] C_CL_LOAD  = 3'd2;
    localparam logic [2:0] C_CL_LDI   = 3'd3;
    localparam logic [2:0] C_CL_STORE = 3'd4;
    localparam logic [2:0] C_CL_DISP  = 3'd5;
    localparam logic [2:0] C_CL_DISPM = 3'd6;
    localparam logic [2:0] C_CL_ILL   = 3'd7;

    localparam int C_CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_WAIT_LAST = C_CNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]          r_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic [TYPE_W-1:0]   r_type;
    logic [C_CNT_W-1:0]  r_wait;

    logic [2:0] w_next;
    logic [2:0] w_class;
    logic       w_imm;
    logic       w_run;

    // Class decode of the latched instruction
    always_comb begin
        w_class = C_CL_ILL;
        w_imm   = 1'b0;
        if (r_type == TYPE_W'(0)) begin
            if ((r_opcode >= OPCODE_W'(3) && r_opcode <= OPCODE_W'(6)) ||
                (r_opcode >= OPCODE_W'(8) && r_opcode <= OPCODE_W'(15))) begin
                w_class = C_CL_ALU;
            end else if (r_opcode == OPCODE_W'(7) || r_opcode == OPCODE_W'(25) ||
                         (r_opcode >= OPCODE_W'(16) && r_opcode <= OPCODE_W'(19))) begin
                w_class = C_CL_CMP;
            end
            w_imm = (r_opcode == OPCODE_W'(4))  || (r_opcode == OPCODE_W'(6))  ||
                    (r_opcode == OPCODE_W'(7))  || (r_opcode == OPCODE_W'(15)) ||
                    (r_opcode == OPCODE_W'(17)) || (r_opcode == OPCODE_W'(19));
        end else if (r_type == TYPE_W'(1)) begin
            if (r_opcode == OPCODE_W'(0))      w_class = C_CL_LOAD;
            else if (r_opcode == OPCODE_W'(1)) w_class = C_CL_LDI;
            else if (r_opcode == OPCODE_W'(2)) w_class = C_CL_STORE;
        end else if (r_type == TYPE_W'(3)) begin
            if (r_opcode == OPCODE_W'(21) || r_opcode == OPCODE_W'(22) ||
                r_opcode == OPCODE_W'(24))       w_class = C_CL_DISP;
            else if (r_opcode == OPCODE_W'(23)) w_class = C_CL_DISPM;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_ST_FETCH: begin
                if (instr_valid) w_next = C_ST_DECODE;
            end
            C_ST_DECODE: begin
                case (w_class)
                    C_CL_LDI:   w_next = C_ST_WB;
                    C_CL_DISP:  w_next = C_ST_DISPLAY;
                    C_CL_DISPM: w_next = C_ST_MEM;
                    C_CL_ILL:   w_next = C_ST_TRAP;
                    default:    w_next = C_ST_EXECUTE;
                endcase
            end
            C_ST_EXECUTE: begin
                case (w_class)
                    C_CL_CMP:              w_next = C_ST_FETCH;
                    C_CL_LOAD, C_CL_STORE: w_next = C_ST_MEM;
                    default:               w_next = C_ST_WB;
                endcase
            end
            C_ST_MEM: begin
                // An ack on the final allowed cycle still completes normally
                if (mem_ack) begin
                    case (w_class)
                        C_CL_LOAD:  w_next = C_ST_WB;
                        C_CL_DISPM: w_next = C_ST_DISPLAY;
                        default:    w_next = C_ST_FETCH;
                    endcase
                end else if (r_wait == C_WAIT_LAST) begin
                    w_next = C_ST_TRAP;
                end
            end
            default: w_next = C_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= C_ST_FETCH;
            r_opcode <= '0;
            r_type   <= '0;
            r_wait   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == C_ST_FETCH && instr_valid) begin
                r_opcode <= opcode;
                r_type   <= instr_type;
            end
            // Held at zero outside MEM so every MEM entry starts from zero
            if (r_state != C_ST_MEM)  r_wait <= '0;
            else if (!mem_ack)        r_wait <= r_wait + C_CNT_W'(1);
        end
    end

    // All outputs are forced low while rst is asserted
    assign w_run = ~rst;

    always_comb begin
        instr_ready  = w_run && (r_state == C_ST_FETCH);
        ir_load      = instr_ready && instr_valid;
        mem_read_en  = w_run && (r_state == C_ST_MEM) &&
                       (w_class == C_CL_LOAD || w_class == C_CL_DISPM);
        mem_write_en = w_run && (r_state == C_ST_MEM) && (w_class == C_CL_STORE);
        reg_write_en = w_run && (r_state == C_ST_WB);
        data_to_reg  = 2'b00;
        if (reg_write_en) begin
            case (w_class)
                C_CL_LOAD: data_to_reg = 2'b01;
                C_CL_LDI:  data_to_reg = 2'b11;
                default:   data_to_reg = 2'b10;
            endcase
        end
        alu_imm      = w_run && (r_state != C_ST_FETCH) && w_imm;
        flag_en      = w_run && (r_state == C_ST_EXECUTE) && (w_class == C_CL_CMP);
        display      = w_run && (r_state == C_ST_DISPLAY);
        // A store finishes in the MEM cycle that samples its ack
        instr_done   = w_run && ((r_state == C_ST_WB) || (r_state == C_ST_DISPLAY) ||
                                 (r_state == C_ST_TRAP) || flag_en ||
                                 (mem_write_en && mem_ack));
        // Only legal classes reach MEM, so a TRAP for a legal class is a timeout
        illegal      = w_run && (r_state == C_ST_TRAP) && (w_class == C_CL_ILL);
        mem_timeout  = w_run && (r_state == C_ST_TRAP) && (w_class != C_CL_ILL);
        state        = w_run ? r_state : C_ST_FETCH;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Randomised bench for multicycle_control_unit. Each instruction
//               is expanded into its expected phase sequence from the class
//               rules, and every cycle's outputs are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int C_TIMEOUT = 4;

    // Packed observation layout:
    // [15] ready [14] ir_load [13] rd [12] wr [11] rw [10:9] dtr [8] imm
    // [7] flag [6] display [5] done [4] illegal [3] timeout [2:0] state
    localparam logic [15:0] C_RDY  = 16'h8000;
    localparam logic [15:0] C_IRL  = 16'h4000;
    localparam logic [15:0] C_RD   = 16'h2000;
    localparam logic [15:0] C_WR   = 16'h1000;
    localparam logic [15:0] C_RW   = 16'h0800;
    localparam logic [15:0] C_DMEM = 16'h0200;
    localparam logic [15:0] C_DALU = 16'h0400;
    localparam logic [15:0] C_DIMM = 16'h0600;
    localparam logic [15:0] C_IMM  = 16'h0100;
    localparam logic [15:0] C_FLG  = 16'h0080;
    localparam logic [15:0] C_DSP  = 16'h0040;
    localparam logic [15:0] C_DONE = 16'h0020;
    localparam logic [15:0] C_ILL  = 16'h0010;
    localparam logic [15:0] C_TO   = 16'h0008;

    localparam int K_ALU = 0, K_CMP = 1, K_LOAD = 2, K_LDI = 3;
    localparam int K_STORE = 4, K_DISP = 5, K_DISPM = 6, K_ILL = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [4:0] opcode;
    logic [1:0] instr_type;
    logic       mem_ack;
    logic       ir_load, mem_read_en, mem_write_en, reg_write_en;
    logic [1:0] data_to_reg;
    logic       alu_imm, flag_en, display, instr_done, illegal, mem_timeout;
    logic [2:0] state;
    logic [15:0] obs;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] v;
        logic        ack;
        logic        rnd_ack;
    } cyc_t;

    logic [1:0] legal_t[$];
    logic [4:0] legal_op[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OPCODE_W    (5),
        .TYPE_W      (2),
        .MEM_TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .instr_type   (instr_type),
        .mem_ack      (mem_ack),
        .ir_load      (ir_load),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .reg_write_en (reg_write_en),
        .data_to_reg  (data_to_reg),
        .alu_imm      (alu_imm),
        .flag_en      (flag_en),
        .display      (display),
        .instr_done   (instr_done),
        .illegal      (illegal),
        .mem_timeout  (mem_timeout),
        .state        (state)
    );

    assign obs = {instr_ready, ir_load, mem_read_en, mem_write_en, reg_write_en,
                  data_to_reg, alu_imm, flag_en, display, instr_done, illegal,
                  mem_timeout, state};

    task automatic check_vec(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [1:0] t, input logic [4:0] op);
        int o;
        o = int'(op);
        case (t)
            2'd0: begin
                if ((o >= 3 && o <= 6) || (o >= 8 && o <= 15)) return K_ALU;
                if (o == 7 || (o >= 16 && o <= 19) || o == 25) return K_CMP;
            end
            2'd1: begin
                if (o == 0) return K_LOAD;
                if (o == 1) return K_LDI;
                if (o == 2) return K_STORE;
            end
            2'd3: begin
                if (o == 21 || o == 22 || o == 24) return K_DISP;
                if (o == 23) return K_DISPM;
            end
            default: ;
        endcase
        return K_ILL;
    endfunction

    function automatic logic is_imm(input logic [1:0] t, input logic [4:0] op);
        int o;
        o = int'(op);
        return (t == 2'd0) && (o == 4 || o == 6 || o == 7 || o == 15 || o == 17 || o == 19);
    endfunction

    function automatic cyc_t cy(input int st, input logic [15:0] m, input logic a,
                                input logic r);
        cyc_t c;
        c.v       = m | 16'(st);
        c.ack     = a;
        c.rnd_ack = r;
        return c;
    endfunction

    // ack_n: MEM cycle (1-based) on which mem_ack is given, 0 = never.
    // rst_at: trace index at which rst is pulsed, -1 = none.
    task automatic run_instr(input logic [1:0] t, input logic [4:0] op, input int idle,
                             input int ack_n, input int rst_at);
        cyc_t        tr[$];
        int          k;
        int          m;
        logic [15:0] im;
        string       nm;
        k  = classify(t, op);
        im = is_imm(t, op) ? C_IMM : 16'h0;
        case (k)
            K_ALU:   nm = "alu";
            K_CMP:   nm = "cmp";
            K_LOAD:  nm = "load";
            K_LDI:   nm = "ldi";
            K_STORE: nm = "store";
            K_DISP:  nm = "disp";
            K_DISPM: nm = "dispm";
            default: nm = "illegal";
        endcase

        for (int i = 0; i < idle; i++) begin
            rst         = 1'b0;
            instr_valid = 1'b0;
            opcode      = 5'($urandom);
            instr_type  = 2'($urandom);
            mem_ack     = 1'($urandom);
            @(negedge clk);
            check_vec("idle", obs, C_RDY);
            @(posedge clk); #1;
        end

        tr.push_back(cy(0, C_RDY | C_IRL, 1'b0, 1'b1));
        tr.push_back(cy(1, im, 1'b0, 1'b1));
        case (k)
            K_ALU: begin
                tr.push_back(cy(2, im, 1'b0, 1'b1));
                tr.push_back(cy(4, im | C_RW | C_DALU | C_DONE, 1'b0, 1'b1));
            end
            K_CMP:  tr.push_back(cy(2, im | C_FLG | C_DONE, 1'b0, 1'b1));
            K_LDI:  tr.push_back(cy(4, im | C_RW | C_DIMM | C_DONE, 1'b0, 1'b1));
            K_DISP: tr.push_back(cy(5, im | C_DSP | C_DONE, 1'b0, 1'b1));
            K_ILL:  tr.push_back(cy(6, im | C_ILL | C_DONE, 1'b0, 1'b1));
            default: begin
                if (k != K_DISPM) tr.push_back(cy(2, im, 1'b0, 1'b1));
                m = (ack_n == 0) ? C_TIMEOUT : ack_n;
                for (int j = 1; j <= m; j++) begin
                    tr.push_back(cy(3, im | ((k == K_STORE) ? C_WR : C_RD) |
                                       ((k == K_STORE && j == ack_n) ? C_DONE : 16'h0),
                                    (j == ack_n), 1'b0));
                end
                if (ack_n == 0)         tr.push_back(cy(6, im | C_TO | C_DONE, 1'b0, 1'b1));
                else if (k == K_LOAD)   tr.push_back(cy(4, im | C_RW | C_DMEM | C_DONE, 1'b0, 1'b1));
                else if (k == K_DISPM)  tr.push_back(cy(5, im | C_DSP | C_DONE, 1'b0, 1'b1));
            end
        endcase

        for (int i = 0; i < tr.size(); i++) begin
            rst         = (i == rst_at);
            instr_valid = (i == 0);
            opcode      = (i == 0) ? op : 5'($urandom);
            instr_type  = (i == 0) ? t  : 2'($urandom);
            // A pending ack during reset must be ignored
            mem_ack     = (i == rst_at) ? 1'b1 :
                          (tr[i].rnd_ack ? 1'($urandom) : tr[i].ack);
            @(negedge clk);
            check_vec($sformatf("%s c%0d", nm, i), obs, (i == rst_at) ? 16'h0 : tr[i].v);
            @(posedge clk); #1;
            if (i == rst_at) break;
        end
        rst = 1'b0;
    endtask

    initial begin
        int ack_n;
        int rst_at;
        int sel;
        for (int ti = 0; ti < 4; ti++) begin
            for (int oi = 0; oi < 32; oi++) begin
                if (classify(2'(ti), 5'(oi)) != K_ILL) begin
                    legal_t.push_back(2'(ti));
                    legal_op.push_back(5'(oi));
                end
            end
        end

        rst         = 1'b1;
        instr_valid = 1'b1;
        opcode      = 5'd4;
        instr_type  = 2'd0;
        mem_ack     = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_vec("reset", obs, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_vec("reset", obs, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed sequences
        run_instr(2'd0, 5'd4,  0, 0, -1);  // add-imm
        run_instr(2'd1, 5'd0,  0, 3, -1);  // load, ack on 3rd MEM cycle
        run_instr(2'd1, 5'd2,  0, 0, -1);  // store, no ack -> timeout
        run_instr(2'd1, 5'd2,  0, C_TIMEOUT, -1);  // store, ack on last cycle
        run_instr(2'd2, 5'd3,  1, 0, -1);  // illegal type
        run_instr(2'd0, 5'd31, 0, 0, -1);  // illegal opcode
        run_instr(2'd0, 5'd19, 0, 0, -1);  // compare-imm
        run_instr(2'd3, 5'd23, 0, 2, -1);  // display-memory back-to-back
        run_instr(2'd1, 5'd0,  0, 3, 4);   // load reset in MEM
        run_instr(2'd1, 5'd1,  0, 0, -1);  // load-imm
        run_instr(2'd3, 5'd21, 0, 0, -1);  // display
        run_instr(2'd3, 5'd23, 0, 1, -1);  // display-memory, immediate ack

        for (int n = 0; n < 400; n++) begin
            logic [1:0] t;
            logic [4:0] op;
            if ($urandom_range(3) != 0) begin
                sel = $urandom_range(legal_t.size() - 1);
                t   = legal_t[sel];
                op  = legal_op[sel];
            end else begin
                t  = 2'($urandom);
                op = 5'($urandom);
            end
            ack_n  = $urandom_range(C_TIMEOUT);
            rst_at = ($urandom_range(15) == 0) ? $urandom_range(6) : -1;
            run_instr(t, op, ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0,
                      ack_n, rst_at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
